param_seq_detector: RTL and testbench

PARAM_SEQ_DETECTOR -- requirements
Module: param_seq_detector

---
 rtl/seq_det_pkg.sv | 17 +
 rtl/seq_det_hist.sv | 63 ++++++
 rtl/param_seq_detector.sv | 137 +++++++++++++
 tb/tb_param_seq_detector.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// seq_det_pkg -- shared constants for the parameterised sequence detector.
//
// Holds the default parameter values used by param_seq_detector and
// seq_det_hist, and the helper that sizes the pattern-length / fill-count
// fields (LW = $clog2(MAX_LEN) + 1, wide enough to hold MAX_LEN itself).
package seq_det_pkg;

  localparam int         SEQ_DEF_MAX_LEN = 8;
  localparam int         SEQ_DEF_LEN     = 4;
  localparam logic [7:0] SEQ_DEF_PATTERN = 8'b0000_1000;
  localparam int         SEQ_DEF_CNT_W   = 8;

  function automatic int seq_det_lw(input int max_len);
    return $clog2(max_len) + 1;
  endfunction

endpackage

// File: rtl/seq_det_hist.sv
// seq_det_hist -- serial history shift register with saturating fill count.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   clear_i        clear history and fill (wins over shift)
//   shift_i        shift x_i into bit 0 and bump fill
//   x_i            serial data bit
//   fill_clr_i     on a shift cycle, drop fill to 0 instead of incrementing
//   hist_nxt_o     history as it would be after shifting x_i in
//   fill_nxt_o     fill as it would be after a saturating increment
//
// The *_nxt_o outputs are combinational look-ahead values so the compare in
// the top module can judge the bit being sampled this cycle. They never
// depend on fill_clr_i, so using the compare result to drive fill_clr_i
// forms no combinational loop.
module seq_det_hist
  import seq_det_pkg::*;
#(
  parameter  int MAX_LEN = SEQ_DEF_MAX_LEN,
  localparam int LW      = seq_det_lw(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_i,
  input  logic               shift_i,
  input  logic               x_i,
  input  logic               fill_clr_i,
  output logic [MAX_LEN-1:0] hist_nxt_o,
  output logic [LW-1:0]      fill_nxt_o
);

  logic [MAX_LEN-1:0] hist_q, hist_d, hist_sh;
  logic [LW-1:0]      fill_q, fill_d, fill_inc;

  assign hist_sh  = {hist_q[MAX_LEN-2:0], x_i};
  assign fill_inc = (fill_q == LW'(MAX_LEN)) ? fill_q : fill_q + LW'(1);

  assign hist_nxt_o = hist_sh;
  assign fill_nxt_o = fill_inc;

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clear_i) begin
      hist_d = '0;
      fill_d = '0;
    end else if (shift_i) begin
      hist_d = hist_sh;
      fill_d = fill_clr_i ? '0 : fill_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/param_seq_detector.sv
// param_seq_detector -- run-time configurable serial pattern detector.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   x, x_valid     serial bit stream; x is taken only on cycles with
//                  x_valid=1 (no back-pressure: the detector always accepts)
//   cfg_load       load cfg_pattern/cfg_len/cfg_overlap; wins over x_valid
//   cfg_pattern    pattern, bit 0 = most recent bit
//   cfg_len        pattern length (1..MAX_LEN valid)
//   cfg_overlap    1 = overlapping detection, 0 = restart after a match
//   y              registered one-cycle match pulse
//   cfg_err        active configuration has an illegal length
//   match_cnt      saturating match count since load/reset
//
// Build option: define SEQDET_MATCH_CNT_EN to build the match counter;
// otherwise match_cnt is tied to 0 and no counter flops exist.
module param_seq_detector
  import seq_det_pkg::*;
#(
  parameter  int               MAX_LEN     = SEQ_DEF_MAX_LEN,
  parameter  int               DEF_LEN     = SEQ_DEF_LEN,
  parameter  logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(SEQ_DEF_PATTERN),
  parameter  int               CNT_W       = SEQ_DEF_CNT_W,
  localparam int               LW          = seq_det_lw(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               x,
  input  logic               x_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LW-1:0]      cfg_len,
  input  logic               cfg_overlap,
  output logic               y,
  output logic               cfg_err,
  output logic [CNT_W-1:0]   match_cnt
);

  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LW-1:0]      len_q, len_d;
  logic               overlap_q, overlap_d;
  logic               y_q, y_d;
  logic               err_q, err_d;

  logic [MAX_LEN-1:0] hist_nxt;
  logic [LW-1:0]      fill_nxt;
  logic [MAX_LEN-1:0] len_mask;
  logic               shift;
  logic               match;

  // A load discards the bit offered in the same cycle.
  assign shift = x_valid & ~cfg_load;

  seq_det_hist #(
    .MAX_LEN(MAX_LEN)
  ) u_hist (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (cfg_load),
    .shift_i    (shift),
    .x_i        (x),
    .fill_clr_i (match & ~overlap_q),
    .hist_nxt_o (hist_nxt),
    .fill_nxt_o (fill_nxt)
  );

  // Only the low len bits take part in the compare.
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (LW'(i) < len_q);
    end
  end

  assign match = shift & ~err_q & (fill_nxt >= len_q) &
                 (((hist_nxt ^ pattern_q) & len_mask) == '0);

  always_comb begin
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    err_d     = err_q;
    y_d       = match;
    if (cfg_load) begin
      pattern_d = cfg_pattern;
      len_d     = cfg_len;
      overlap_d = cfg_overlap;
      err_d     = (cfg_len == '0) || (cfg_len > LW'(MAX_LEN));
      y_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern_q <= DEF_PATTERN;
      len_q     <= LW'(DEF_LEN);
      overlap_q <= 1'b1;
      err_q     <= 1'b0;
      y_q       <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      err_q     <= err_d;
      y_q       <= y_d;
    end
  end

  assign y       = y_q;
  assign cfg_err = err_q;

`ifdef SEQDET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (cfg_load) begin
      cnt_d = '0;
    end else if (match && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_cnt = cnt_q;
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_param_seq_detector.sv
// tb_param_seq_detector -- directed scoreboard bench for param_seq_detector.
//
// Each driven cycle pushes the expected {y, cfg_err, match_cnt} into exp_q;
// a monitor samples the outputs 2 time units after every clock edge and pops
// one entry whenever the queue holds one. The DUT uses CNT_W=2 so counter
// saturation is reachable in a few matches.
module tb_param_seq_detector;

  localparam int MAX_LEN = 8;
  localparam int LW      = 4;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef SEQDET_MATCH_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic               clk = 1'b0;
  logic               rst;
  logic               x;
  logic               x_valid;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LW-1:0]      cfg_len;
  logic               cfg_overlap;
  logic               y;
  logic               cfg_err;
  logic [CNT_W-1:0]   match_cnt;

  always #5 clk = ~clk;

  param_seq_detector #(
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .x           (x),
    .x_valid     (x_valid),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .y           (y),
    .cfg_err     (cfg_err),
    .match_cnt   (match_cnt)
  );

  // ---------------- scoreboard ----------------
  logic [CNT_W+1:0] exp_q[$];
  int               checks = 0;
  int               errors = 0;
  int               cnt_m  = 0;
  logic             err_m  = 1'b0;

  task automatic push_exp(input logic ey, input logic ee);
    logic [CNT_W-1:0] ec;
    ec = CNT_EN ? CNT_W'(cnt_m) : '0;
    exp_q.push_back({ey, ee, ec});
  endtask

  initial begin : monitor
    logic [CNT_W+1:0] e;
    logic [CNT_W+1:0] got;
    forever begin
      @(clk);
      #2;
      if (exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        got = {y, cfg_err, match_cnt};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL out#%0d @%0t y/err/cnt got %b/%b/%0d expected %b/%b/%0d",
                   checks, $time, got[CNT_W+1], got[CNT_W], got[CNT_W-1:0],
                   e[CNT_W+1], e[CNT_W], e[CNT_W-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One call = one clock cycle; inputs are changed on the falling edge.
  task automatic drive(input logic xv, input logic xb, input logic ld,
                       input logic [MAX_LEN-1:0] pat, input logic [LW-1:0] ln,
                       input logic ov, input logic ey, input logic ee);
    @(negedge clk);
    x_valid  = xv;
    x        = xb;
    cfg_load = ld;
    if (ld) begin
      cfg_pattern = pat;
      cfg_len     = ln;
      cfg_overlap = ov;
    end
    @(posedge clk);
    #1;
    if (ld)                          cnt_m = 0;
    else if (ey && cnt_m < CNT_MAX)  cnt_m = cnt_m + 1;
    err_m = ee;
    push_exp(ey, ee);
    x_valid  = 1'b0;
    cfg_load = 1'b0;
  endtask

  task automatic bit_in(input logic xb, input logic ey);
    drive(1'b1, xb, 1'b0, cfg_pattern, cfg_len, cfg_overlap, ey, err_m);
  endtask

  task automatic gap();
    drive(1'b0, 1'b0, 1'b0, cfg_pattern, cfg_len, cfg_overlap, 1'b0, err_m);
  endtask

  task automatic load(input logic [MAX_LEN-1:0] pat, input logic [LW-1:0] ln,
                      input logic ov, input logic ee);
    drive(1'b0, 1'b0, 1'b1, pat, ln, ov, 1'b0, ee);
  endtask

  // Asserts rst between clock edges and expects all outputs to drop at once.
  task automatic reset_now();
    #2;
    rst   = 1'b1;
    cnt_m = 0;
    err_m = 1'b0;
    push_exp(1'b0, 1'b0);
    @(negedge clk);
    #3;
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : stimulus
    rst         = 1'b1;
    x           = 1'b0;
    x_valid     = 1'b0;
    cfg_load    = 1'b0;
    cfg_pattern = 8'h08;
    cfg_len     = 4'd4;
    cfg_overlap = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    push_exp(1'b0, 1'b0);
    @(negedge clk);
    #3;
    rst = 1'b0;

    // Default pattern 1000 after reset.
    bit_in(1, 0); bit_in(0, 0); bit_in(0, 0); bit_in(0, 1);
    bit_in(0, 0);

    // 101, overlapping; upper pattern bits set but must be ignored.
    load(8'b1111_1101, 4'd3, 1'b1, 1'b0);
    bit_in(1, 0); bit_in(0, 0); bit_in(1, 1); bit_in(0, 0); bit_in(1, 1);

    // 101, non-overlapping.
    load(8'b0000_0101, 4'd3, 1'b0, 1'b0);
    bit_in(1, 0); bit_in(0, 0); bit_in(1, 1); bit_in(0, 0); bit_in(1, 0);

    // 1000 with idle cycles between bits.
    load(8'h08, 4'd4, 1'b1, 1'b0);
    bit_in(1, 0); gap(); bit_in(0, 0); gap(); gap();
    bit_in(0, 0); gap(); bit_in(0, 1); gap();

    // Load collides with a valid bit: the bit is discarded.
    bit_in(1, 0); bit_in(0, 0); bit_in(0, 0);
    drive(1'b1, 1'b0, 1'b1, 8'h08, 4'd4, 1'b1, 1'b0, 1'b0);
    bit_in(0, 0);
    bit_in(1, 0); bit_in(0, 0); bit_in(0, 0); bit_in(0, 1);

    // Illegal lengths: 0 and MAX_LEN+1.
    load(8'hFF, 4'd0, 1'b1, 1'b1);
    bit_in(1, 0); bit_in(1, 0); bit_in(1, 0); bit_in(1, 0);
    load(8'hFF, 4'd9, 1'b1, 1'b1);
    bit_in(1, 0); bit_in(1, 0); bit_in(1, 0); bit_in(1, 0);
    bit_in(1, 0); bit_in(1, 0); bit_in(1, 0); bit_in(1, 0); bit_in(1, 0);

    // Reset clears cfg_err and restores the default pattern.
    reset_now();
    bit_in(1, 0); bit_in(0, 0); bit_in(0, 0); bit_in(0, 1);

    // Full-width pattern 1010_0101 (len = MAX_LEN).
    load(8'hA5, 4'd8, 1'b1, 1'b0);
    bit_in(1, 0); bit_in(0, 0); bit_in(1, 0); bit_in(0, 0);
    bit_in(0, 0); bit_in(1, 0); bit_in(0, 0); bit_in(1, 1);
    bit_in(0, 0);

    // Single-bit pattern: five matches saturate a 2-bit counter at 3.
    load(8'h01, 4'd1, 1'b1, 1'b0);
    bit_in(1, 1); bit_in(1, 1); bit_in(1, 1); bit_in(1, 1); bit_in(1, 1);
    bit_in(0, 0);

    // Reset while y is high drops it without a clock edge.
    load(8'h08, 4'd4, 1'b1, 1'b0);
    bit_in(1, 0); bit_in(0, 0); bit_in(0, 0); bit_in(0, 1);
    reset_now();

    // Reset mid-sequence loses the partial 1,0,0.
    bit_in(1, 0); bit_in(0, 0); bit_in(0, 0);
    reset_now();
    bit_in(0, 0);
    bit_in(1, 0); bit_in(0, 0); bit_in(0, 0); bit_in(0, 1);
    gap();

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    #3;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
